// File: rtl/fsm_observer_if.sv
// -----------------------------------------------------------------------------
// fsm_observer_if
// Receive link that carries one transmitter step per clock to the observer.
//   vld : this cycle carries a valid (m, n) step
//   m   : transmitter output m
//   n   : transmitter output n
// The master side drives the link (link receiver / testbench). The slave side
// is the observer.
// -----------------------------------------------------------------------------
interface fsm_observer_if;
    logic vld;
    logic m;
    logic n;

    modport master (
        output vld,
        output m,
        output n
    );

    modport slave (
        input vld,
        input m,
        input n
    );
endinterface

// File: rtl/fsm_observer.sv
// -----------------------------------------------------------------------------
// fsm_observer
// Receive-side observer for the 5-state Mealy transmitter that maps (a, b) to
// (m, n). It keeps the set of transmitter states consistent with every (m, n)
// step seen since reset. Where the step identifies a and/or b it recovers them,
// and it flags any step the transmitter could not have produced.
//
// Ports
//   clk      : clock, rising edge
//   rst_b    : asynchronous active-low reset
//   link     : slave side of fsm_observer_if (vld, m, n)
//   cand     : candidate state set, bit i = transmitter may be in Si
//   lock     : exactly one candidate remains (decoded from cand register)
//   a_known  : a_dec is valid for the last accepted step
//   a_dec    : recovered a (0 when not known)
//   b_known  : b_dec is valid for the last accepted step
//   b_dec    : recovered b (0 when not known)
//   err      : one-cycle pulse, last accepted step impossible from every state
//   err_cnt  : saturating count of err pulses
// -----------------------------------------------------------------------------
module fsm_observer (
    input  logic                 clk,
    input  logic                 rst_b,
    fsm_observer_if.slave        link,
    output logic [4:0]           cand,
    output logic                 lock,
    output logic                 a_known,
    output logic                 a_dec,
    output logic                 b_known,
    output logic                 b_dec,
    output logic                 err,
    output logic [3:0]           err_cnt
);

    // Summary of every transition one state allows for one observed (m, n):
    // the union of targets and, for a and b separately, which values occur
    // (0, 1) and whether any transition leaves the bit undetermined.
    typedef struct packed {
        logic [4:0] tgt;
        logic       a0;
        logic       a1;
        logic       au;
        logic       b0;
        logic       b1;
        logic       bu;
    } step_t;

    localparam logic [4:0] RESET_CAND = 5'b00001;
    localparam logic [4:0] ALL_CAND   = 5'b11111;
    localparam logic [3:0] CNT_MAX    = 4'd15;

    // Transition table of the transmitter, read backwards: given the state the
    // transmitter was in and the (m, n) it emitted, which states can follow and
    // what (a, b) must have been applied. An all-zero tgt means impossible.
    function automatic step_t state_step(input logic [2:0] idx,
                                         input logic [1:0] mn);
        step_t s;
        s = '0;
        case (idx)
            3'd0: begin
                case (mn)
                    2'b00: begin s.tgt = 5'b00001; s.a0 = 1'b1; s.bu = 1'b1; end
                    2'b10: begin s.tgt = 5'b10000; s.a1 = 1'b1; s.b1 = 1'b1; end
                    2'b01: begin s.tgt = 5'b00010; s.a1 = 1'b1; s.b0 = 1'b1; end
                    default: s = '0;
                endcase
            end
            3'd1: begin
                case (mn)
                    2'b11:   begin s.tgt = 5'b00100; s.au = 1'b1; s.bu = 1'b1; end
                    default: s = '0;
                endcase
            end
            3'd2: begin
                case (mn)
                    2'b01: begin s.tgt = 5'b10000; s.a0 = 1'b1; s.bu = 1'b1; end
                    2'b10: begin s.tgt = 5'b01000; s.a1 = 1'b1; s.bu = 1'b1; end
                    default: s = '0;
                endcase
            end
            3'd3: begin
                // S3 is nondeterministic as seen from (m, n): both branches
                // agree on a but disagree on b, so b can never be recovered.
                case (mn)
                    2'b00: begin
                        s.tgt = 5'b11000; s.a1 = 1'b1; s.b0 = 1'b1; s.b1 = 1'b1;
                    end
                    2'b11: begin
                        s.tgt = 5'b01001; s.a0 = 1'b1; s.b0 = 1'b1; s.b1 = 1'b1;
                    end
                    default: s = '0;
                endcase
            end
            3'd4: begin
                case (mn)
                    2'b01: begin s.tgt = 5'b10000; s.au = 1'b1; s.b0 = 1'b1; end
                    2'b11: begin s.tgt = 5'b00010; s.au = 1'b1; s.b1 = 1'b1; end
                    default: s = '0;
                endcase
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    // Population-count-equals-one test for the candidate set.
    function automatic logic one_hot5(input logic [4:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return (cnt == 3'd1);
    endfunction

    // A bit is recoverable only if some transition fired, none left it open,
    // and the transitions do not disagree on its value.
    function automatic logic bit_known(input logic v0, input logic v1,
                                       input logic vu);
        return (v0 | v1) & ~vu & ~(v0 & v1);
    endfunction

    logic [4:0] cand_r;
    logic       a_known_r;
    logic       a_dec_r;
    logic       b_known_r;
    logic       b_dec_r;
    logic       err_r;
    logic [3:0] err_cnt_r;

    step_t      step_s;
    logic [1:0] mn_s;
    logic [4:0] nxt_cand_s;
    logic       a0_s;
    logic       a1_s;
    logic       au_s;
    logic       b0_s;
    logic       b1_s;
    logic       bu_s;
    logic       impossible_s;
    logic       a_known_s;
    logic       b_known_s;
    logic [3:0] nxt_cnt_s;

    assign mn_s = {link.m, link.n};

    // Merge the transitions of every current candidate into the next set and
    // the combined a/b evidence.
    always_comb begin
        step_s     = '0;
        nxt_cand_s = 5'b00000;
        a0_s       = 1'b0;
        a1_s       = 1'b0;
        au_s       = 1'b0;
        b0_s       = 1'b0;
        b1_s       = 1'b0;
        bu_s       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_s = state_step(3'(i), mn_s);
            if (cand_r[i]) begin
                nxt_cand_s = nxt_cand_s | step_s.tgt;
                a0_s       = a0_s | step_s.a0;
                a1_s       = a1_s | step_s.a1;
                au_s       = au_s | step_s.au;
                b0_s       = b0_s | step_s.b0;
                b1_s       = b1_s | step_s.b1;
                bu_s       = bu_s | step_s.bu;
            end else begin
                nxt_cand_s = nxt_cand_s;
            end
        end
    end

    // Derive the decode results and the saturated error count.
    always_comb begin
        impossible_s = (nxt_cand_s == 5'b00000);
        a_known_s    = bit_known(a0_s, a1_s, au_s);
        b_known_s    = bit_known(b0_s, b1_s, bu_s);
        if (err_cnt_r == CNT_MAX) begin
            nxt_cnt_s = CNT_MAX;
        end else begin
            nxt_cnt_s = err_cnt_r + 4'd1;
        end
    end

    // Observer state and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cand_r    <= RESET_CAND;
            a_known_r <= 1'b0;
            a_dec_r   <= 1'b0;
            b_known_r <= 1'b0;
            b_dec_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 4'd0;
        end else if (link.vld) begin
            if (impossible_s) begin
                // Lost track of the transmitter: resync by allowing any state.
                cand_r    <= ALL_CAND;
                a_known_r <= 1'b0;
                a_dec_r   <= 1'b0;
                b_known_r <= 1'b0;
                b_dec_r   <= 1'b0;
                err_r     <= 1'b1;
                err_cnt_r <= nxt_cnt_s;
            end else begin
                cand_r    <= nxt_cand_s;
                a_known_r <= a_known_s;
                a_dec_r   <= a_known_s & a1_s;
                b_known_r <= b_known_s;
                b_dec_r   <= b_known_s & b1_s;
                err_r     <= 1'b0;
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            cand_r    <= cand_r;
            a_known_r <= 1'b0;
            a_dec_r   <= 1'b0;
            b_known_r <= 1'b0;
            b_dec_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= err_cnt_r;
        end
    end

    assign cand    = cand_r;
    assign lock    = one_hot5(cand_r);
    assign a_known = a_known_r;
    assign a_dec   = a_dec_r;
    assign b_known = b_known_r;
    assign b_dec   = b_dec_r;
    assign err     = err_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_fsm_observer.sv
// -----------------------------------------------------------------------------
// tb_fsm_observer
// Self-checking bench for fsm_observer: a directed vector table, hand-written
// multi-cycle sequences (error saturation, asynchronous reset mid-cycle) and a
// randomized run checked against a set-based model of the transmitter table.
// -----------------------------------------------------------------------------
module tb_fsm_observer;

    logic       clk;
    logic       rst_b;
    logic [4:0] cand;
    logic       lock;
    logic       a_known;
    logic       a_dec;
    logic       b_known;
    logic       b_dec;
    logic       err;
    logic [3:0] err_cnt;

    fsm_observer_if link ();

    fsm_observer dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .link    (link),
        .cand    (cand),
        .lock    (lock),
        .a_known (a_known),
        .a_dec   (a_dec),
        .b_known (b_known),
        .b_dec   (b_dec),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transmitter transition list: from state, emitted mn, to state, a, b.
    // a/b value 2 means that input does not affect this transition's output.
    typedef struct {
        int         from;
        logic [1:0] mn;
        int         to;
        int         a;
        int         b;
    } tr_t;
    tr_t trs [12];

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  mn;
        logic [14:0] exp;
    } vec_t;
    vec_t vecs [16];

    // Reference model state
    logic [4:0] m_cand;
    logic       m_ak, m_ad, m_bk, m_bd, m_err;
    logic [3:0] m_cnt;

    function automatic logic [14:0] mk(input logic [4:0] c, input logic l,
                                       input logic ak, input logic ad,
                                       input logic bk, input logic bd,
                                       input logic e, input logic [3:0] cnt);
        return {c, l, ak, ad, bk, bd, e, cnt};
    endfunction

    function automatic logic [14:0] model_vec();
        return mk(m_cand, ($countones(m_cand) == 1), m_ak, m_ad, m_bk, m_bd,
                  m_err, m_cnt);
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {cand, lock, a_known, a_dec, b_known, b_dec, err, err_cnt};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got cand/lock/ak/ad/bk/bd/err/cnt=%b want %b at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cand = 5'b00001;
        m_ak = 1'b0; m_ad = 1'b0; m_bk = 1'b0; m_bd = 1'b0; m_err = 1'b0;
        m_cnt = 4'd0;
    endtask

    // Set semantics: walk every listed transition from every possible state.
    task automatic model_step(input logic v, input logic [1:0] mn);
        logic [4:0] nx;
        int na0, na1, nau, nb0, nb1, nbu;
        if (!v) begin
            m_ak = 1'b0; m_ad = 1'b0; m_bk = 1'b0; m_bd = 1'b0; m_err = 1'b0;
        end else begin
            nx = 5'b00000;
            na0 = 0; na1 = 0; nau = 0; nb0 = 0; nb1 = 0; nbu = 0;
            for (int t = 0; t < 12; t++) begin
                if (m_cand[trs[t].from] && trs[t].mn == mn) begin
                    nx[trs[t].to] = 1'b1;
                    if (trs[t].a == 0) na0++; else if (trs[t].a == 1) na1++; else nau++;
                    if (trs[t].b == 0) nb0++; else if (trs[t].b == 1) nb1++; else nbu++;
                end
            end
            if (nx == 5'b00000) begin
                m_cand = 5'b11111;
                m_ak = 1'b0; m_ad = 1'b0; m_bk = 1'b0; m_bd = 1'b0;
                m_err = 1'b1;
                if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
            end else begin
                m_cand = nx;
                m_ak = (nau == 0) && ((na0 == 0) != (na1 == 0));
                m_ad = m_ak && (na1 > 0);
                m_bk = (nbu == 0) && ((nb0 == 0) != (nb1 == 0));
                m_bd = m_bk && (nb1 > 0);
                m_err = 1'b0;
            end
        end
    endtask

    // Drive one step at the falling edge; return 1 ns after the sampling edge.
    task automatic step(input logic v, input logic [1:0] mn);
        @(negedge clk);
        link.vld = v;
        link.m   = mn[1];
        link.n   = mn[0];
        @(posedge clk);
        #1;
    endtask

    // Assert reset between clock edges, check that it acts with no clock edge,
    // then release at the following falling edge with the link idle.
    task automatic pulse_reset(input string name);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        check(name, mk(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        @(negedge clk);
        link.vld = 1'b0;
        rst_b = 1'b1;
        model_reset();
    endtask

    initial begin
        logic       v;
        logic [1:0] mn;
        logic [3:0] cnt_exp;

        trs[0]  = '{0, 2'b00, 0, 0, 2};
        trs[1]  = '{0, 2'b10, 4, 1, 1};
        trs[2]  = '{0, 2'b01, 1, 1, 0};
        trs[3]  = '{1, 2'b11, 2, 2, 2};
        trs[4]  = '{2, 2'b01, 4, 0, 2};
        trs[5]  = '{2, 2'b10, 3, 1, 2};
        trs[6]  = '{3, 2'b00, 3, 1, 0};
        trs[7]  = '{3, 2'b00, 4, 1, 1};
        trs[8]  = '{3, 2'b11, 3, 0, 1};
        trs[9]  = '{3, 2'b11, 0, 0, 0};
        trs[10] = '{4, 2'b01, 4, 2, 0};
        trs[11] = '{4, 2'b11, 1, 2, 1};

        //          rst   vld   mn      cand      lk  ak  ad  bk  bd  err cnt
        vecs[0]  = '{1'b1, 1'b0, 2'b00, mk(5'b00001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, mk(5'b00010,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0)};
        vecs[2]  = '{1'b0, 1'b1, 2'b11, mk(5'b00100,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[3]  = '{1'b0, 1'b1, 2'b10, mk(5'b01000,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0)};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, mk(5'b11000,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0)};
        vecs[5]  = '{1'b0, 1'b1, 2'b01, mk(5'b10000,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0)};
        vecs[6]  = '{1'b0, 1'b0, 2'b11, mk(5'b10000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, mk(5'b10000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, mk(5'b10000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, mk(5'b00001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[10] = '{1'b0, 1'b1, 2'b11, mk(5'b11111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd1)};
        vecs[11] = '{1'b0, 1'b1, 2'b01, mk(5'b10010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1)};
        vecs[12] = '{1'b0, 1'b0, 2'b01, mk(5'b10010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1)};
        vecs[13] = '{1'b0, 1'b1, 2'b01, mk(5'b10000,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,4'd1)};
        vecs[14] = '{1'b1, 1'b0, 2'b00, mk(5'b00001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0)};
        vecs[15] = '{1'b0, 1'b1, 2'b10, mk(5'b10000,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd0)};

        rst_b    = 1'b0;
        link.vld = 1'b0;
        link.m   = 1'b0;
        link.n   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("por", mk(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        rst_b = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) begin
                pulse_reset($sformatf("vec%0d_rst", i));
            end else begin
                step(vecs[i].vld, vecs[i].mn);
                check($sformatf("vec%0d", i), vecs[i].exp);
            end
        end

        // Error counter saturation: each round walks back to a lock on S1,
        // then feeds an mn that S1 cannot emit.
        pulse_reset("sat_rst");
        cnt_exp = 4'd0;
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 2'b10);
            step(1'b1, 2'b01);
            step(1'b1, 2'b11);
            check($sformatf("sat%0d_lock_s1", k),
                  mk(5'b00010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, cnt_exp));
            step(1'b1, 2'b00);
            if (cnt_exp != 4'd15) cnt_exp = cnt_exp + 4'd1;
            check($sformatf("sat%0d_err", k),
                  mk(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cnt_exp));
        end
        step(1'b0, 2'b00);
        check("sat_hold", mk(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15));

        // Reset dropped mid-cycle with vld still high, then stream resumes
        pulse_reset("mid_rst0");
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        pulse_reset("mid_rst1");
        step(1'b1, 2'b10);
        check("after_mid_rst", mk(5'b10000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));

        // Randomized run against the model
        pulse_reset("rand_rst");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset($sformatf("rand%0d_rst", i));
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                mn = 2'($urandom_range(0, 3));
                step(v, mn);
                model_step(v, mn);
                check($sformatf("rand%0d", i), model_vec());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
